// File: rtl/polling_to_irq_master_if.sv
// Avalon-MM read-only bus between the polling master and the polled status slave.
// The master drives a constant address and a held read request; the slave stalls and replies.
interface polling_to_irq_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic                  waitrequest;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdata,
    output readdatavalid
  );
endinterface

// File: rtl/polling_to_irq_master.sv
// Periodically reads a memory-mapped status register over Avalon-MM and regenerates
// a level interrupt from the masked value, flagging reads that never return.
module polling_to_irq_master #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] POLL_ADDR     = '0,
  parameter int                    POLL_INTERVAL = 256,
  parameter int                    TIMEOUT       = 1024,
  parameter logic [DATA_WIDTH-1:0] IRQ_MASK      = '1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  polling_to_irq_master_if.master avm,
  output logic [DATA_WIDTH-1:0]   irq_status,
  output logic                    interrupt,
  output logic                    read_timeout
);

  localparam int IW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] INTERVAL_LAST = IW'(POLL_INTERVAL - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA
  } state_t;

  state_t                state_q,    state_d;
  logic [IW-1:0]         interval_q, interval_d;
  logic [TW-1:0]         timeout_q,  timeout_d;
  logic [DATA_WIDTH-1:0] status_q,   status_d;
  logic                  irq_q,      irq_d;
  logic                  to_q,       to_d;

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples the pre-edge values; reset is synchronous and wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      interval_q <= '0;
      timeout_q  <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      interval_q <= interval_d;
      timeout_q  <= timeout_d;
      status_q   <= status_d;
      irq_q      <= irq_d;
      to_q       <= to_d;
    end
  end

  // NOTE: every variable gets its hold value first, so no branch can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    interval_d = interval_q;
    timeout_d  = timeout_q;
    status_d   = status_q;
    irq_d      = irq_q;
    to_d       = to_q;

    unique case (state_q)
      IDLE: begin
        if (!enable) begin
          interval_d = '0;
        end else if (interval_q == INTERVAL_LAST) begin
          interval_d = '0;
          state_d    = REQ;
        end else begin
          interval_d = interval_q + 1'b1;
        end
      end

      // The request stays up until accepted; enable is deliberately ignored here.
      REQ: begin
        if (!avm.waitrequest) begin
          timeout_d = '0;
          state_d   = WAIT_DATA;
        end
      end

      // A reply on the same edge as the timeout is treated as a good read.
      WAIT_DATA: begin
        if (avm.readdatavalid) begin
          status_d = avm.readdata;
          irq_d    = |(avm.readdata & IRQ_MASK);
          to_d     = 1'b0;
          state_d  = IDLE;
        end else if (timeout_q == TIMEOUT_LAST) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign avm.address  = POLL_ADDR;
  assign avm.read     = (state_q == REQ);
  assign irq_status   = status_q;
  assign interrupt    = irq_q;
  assign read_timeout = to_q;

endmodule

// File: tb/tb_polling_to_irq_master.sv
// Randomised bench for polling_to_irq_master: a scripted Avalon slave plus a
// transaction-level model of what each poll must leave on the outputs.
module tb_polling_to_irq_master;

  localparam int              DW    = 32;
  localparam int              AW    = 32;
  localparam int              PI    = 8;
  localparam int              TO    = 12;
  localparam logic [AW-1:0]   PADDR = 32'h0000_0040;
  localparam logic [DW-1:0]   MASK  = 32'hFFFF_FFFD;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] irq_status;
  logic          interrupt;
  logic          read_timeout;

  polling_to_irq_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) avm ();

  polling_to_irq_master #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .POLL_ADDR    (PADDR),
    .POLL_INTERVAL(PI),
    .TIMEOUT      (TO),
    .IRQ_MASK     (MASK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .avm         (avm),
    .irq_status  (irq_status),
    .interrupt   (interrupt),
    .read_timeout(read_timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_status;
  logic          exp_irq;
  logic          exp_to;
  int            idle_elapsed;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_status"},  irq_status,   exp_status);
    check({tag, "_irq"},     interrupt,    exp_irq);
    check({tag, "_timeout"}, read_timeout, exp_to);
  endtask

  // Edges since the DUT last entered IDLE with enable high must equal PI when read rises.
  task automatic wait_read_rise(input string tag);
    int n    = idle_elapsed;
    bit seen = 1'b0;
    while (!seen && n < PI + 20) begin
      step();
      n++;
      if (avm.read) seen = 1'b1;
    end
    check({tag, "_interval"}, seen ? n : 0, PI);
  endtask

  // One poll: stall cycles of waitrequest, reply sampled lat+1 edges after acceptance.
  // drop: 0 keep enable, 1 drop it during the stall, 2 drop it in the data phase.
  task automatic do_poll(input string tag, input int stall, input int lat, input bit reply,
                         input logic [DW-1:0] data, input int drop);
    int comp, last;
    bit read_bad;
    bit ok;
    wait_read_rise(tag);
    read_bad        = 1'b0;
    avm.waitrequest = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      if (!avm.read) read_bad = 1'b1;
      if (drop == 1 && i == 0) enable = 1'b0;
      step();
    end
    avm.waitrequest = 1'b0;
    if (!avm.read) read_bad = 1'b1;
    check({tag, "_req_held"}, read_bad, 1'b0);
    step();

    ok   = reply && (lat + 1 <= TO);
    comp = ok ? lat + 1 : TO;
    last = (reply && lat + 1 > comp) ? lat + 1 : comp;
    read_bad = 1'b0;
    for (int j = 1; j <= last; j++) begin
      if (drop == 2 && j == 1) enable = 1'b0;
      if (avm.read && j <= comp) read_bad = 1'b1;
      avm.readdatavalid = reply && (j == lat + 1);
      avm.readdata      = (j == lat + 1) ? data : DW'($urandom);
      step();
      avm.readdatavalid = 1'b0;
    end
    check({tag, "_read_low"}, read_bad, 1'b0);

    if (ok) begin
      exp_status = data;
      exp_irq    = |(data & MASK);
      exp_to     = 1'b0;
    end else begin
      exp_to = 1'b1;
    end
    check_outputs(tag);
    idle_elapsed = last - comp;
  endtask

  task automatic hold_disabled(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * PI; i++) begin
      step();
      if (avm.read) seen = 1'b1;
    end
    check({tag, "_no_read"}, seen, 1'b0);
    enable       = 1'b1;
    idle_elapsed = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int stall, lat, drop;
    bit reply;
    logic [DW-1:0] data;

    reset             = 1'b1;
    enable            = 1'b0;
    avm.waitrequest   = 1'b0;
    avm.readdatavalid = 1'b0;
    avm.readdata      = '0;
    exp_status        = '0;
    exp_irq           = 1'b0;
    exp_to            = 1'b0;
    step();
    step();
    check("rst_read", avm.read, 1'b0);
    check_outputs("rst");
    check("address", avm.address, PADDR);
    reset = 1'b0;

    hold_disabled("disabled");

    do_poll("t1a", 0, 1, 1'b1, 32'h4, 0);
    do_poll("t1b", 0, 1, 1'b1, 32'h4, 0);
    do_poll("t2", 5, 1, 1'b1, 32'h10, 0);
    do_poll("t3", 0, TO + 1, 1'b1, 32'h8, 0);
    do_poll("t3b", 0, 2, 1'b1, 32'h0, 0);
    do_poll("t4", 0, 0, 1'b1, 32'h2, 0);
    do_poll("edge_ok", 2, TO - 1, 1'b1, 32'h81, 0);
    do_poll("edge_to", 0, TO, 1'b1, 32'h0, 0);
    do_poll("noreply", 1, 0, 1'b0, 32'h0, 0);
    do_poll("t5", 0, 3, 1'b1, 32'h1, 2);
    hold_disabled("t5");
    do_poll("t5r", 3, 1, 1'b1, 32'h20, 1);
    hold_disabled("t5r");

    for (int k = 0; k < 40; k++) begin
      stall = $urandom_range(0, 4);
      lat   = $urandom_range(0, TO + 1);
      reply = ($urandom_range(0, 3) != 0);
      data  = ($urandom_range(0, 2) == 0) ? (DW'($urandom) & 32'h2) : DW'($urandom);
      drop  = 0;
      if ($urandom_range(0, 7) == 0) drop = (stall > 0) ? $urandom_range(1, 2) : 2;
      do_poll($sformatf("rnd%0d", k), stall, lat, reply, data, drop);
      if (drop != 0) hold_disabled($sformatf("rnd%0d", k));
    end

    // Abort a stalled request with reset.
    do_poll("pre_rst", 0, 0, 1'b1, 32'h5, 0);
    wait_read_rise("t6");
    avm.waitrequest = 1'b1;
    step();
    reset = 1'b1;
    step();
    exp_status = '0;
    exp_irq    = 1'b0;
    exp_to     = 1'b0;
    check("t6_read", avm.read, 1'b0);
    check_outputs("t6");
    reset           = 1'b0;
    avm.waitrequest = 1'b0;
    idle_elapsed    = 0;
    do_poll("post_rst", 0, 1, 1'b1, 32'h4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
